// File: rtl/ucie_ctl_sb_tx_arbiter_if.sv
// Sideband TX arbiter bus: three requester message ports, the credit-return
// pulse, and the outgoing cfg beat stream with its status outputs.
interface ucie_ctl_sb_tx_arbiter_if #(
  parameter int N = 32
);
  logic [2:0]   i_req;
  logic [63:0]  i_msg0;
  logic [63:0]  i_msg1;
  logic [63:0]  i_msg2;
  logic         i_pl_cfg_crd;
  logic [N-1:0] o_lp_cfg;
  logic         o_lp_cfg_vld;
  logic [2:0]   o_grant;
  logic         o_busy;
  logic [3:0]   o_crd_count;
  logic         o_crd_overflow;

  // Arbiter side
  modport slave (
    input  i_req, i_msg0, i_msg1, i_msg2, i_pl_cfg_crd,
    output o_lp_cfg, o_lp_cfg_vld, o_grant, o_busy, o_crd_count, o_crd_overflow
  );

  // Requester / link side
  modport master (
    output i_req, i_msg0, i_msg1, i_msg2, i_pl_cfg_crd,
    input  o_lp_cfg, o_lp_cfg_vld, o_grant, o_busy, o_crd_count, o_crd_overflow
  );
endinterface

// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Sideband TX arbiter: round-robin over three requesters, credit-gated
// capture of a 64-bit message, serialised LSB beat first as 64/N beats.
//
//   state | meaning
//   IDLE  | waiting for a request while at least one remote credit is held
//   SEND  | streaming beats of the captured message, inputs ignored
module ucie_ctl_sb_tx_arbiter #(
  parameter int N       = 32,
  parameter int CRD_MAX = 4
) (
  input logic                     i_clk,
  input logic                     i_rst,
  ucie_ctl_sb_tx_arbiter_if.slave bus
);

  localparam int         B         = 64 / N;
  localparam logic [3:0] CRD_FULL  = 4'(CRD_MAX);
  localparam logic [3:0] BEAT_LAST = 4'(B - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state_q;
  logic [63:0]  msg_q;
  logic [3:0]   beat_q;
  logic [3:0]   crd_q, crd_d;
  logic         ovf_q, ovf_d;
  logic [1:0]   ptr_q;
  logic [2:0]   grant_q;
  logic         vld_q;
  logic [N-1:0] cfg_q;
  logic         busy_q;

  logic         sel_vld;
  logic [1:0]   sel_idx;
  logic [2:0]   sel_oh;
  logic [63:0]  sel_msg;
  logic         capture;

  // Round-robin pick: scan lowest to highest priority so the highest wins
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 2'd0;
    for (int j = 2; j >= 0; j--) begin
      logic [1:0] cand;
      cand = 2'((int'(ptr_q) + j) % 3);
      if (bus.i_req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
    sel_oh = 3'b001 << sel_idx;
    case (sel_idx)
      2'd0:    sel_msg = bus.i_msg0;
      2'd1:    sel_msg = bus.i_msg1;
      default: sel_msg = bus.i_msg2;
    endcase
    capture = (state_q == IDLE) && sel_vld && (crd_q != 4'd0);
  end

  // Credit bookkeeping; a return at full count is dropped and flagged
  always_comb begin
    crd_d = crd_q;
    ovf_d = ovf_q;
    if (bus.i_pl_cfg_crd && !capture) begin
      if (crd_q == CRD_FULL) ovf_d = 1'b1;
      else                   crd_d = crd_q + 4'd1;
    end else if (capture && !bus.i_pl_cfg_crd) begin
      crd_d = crd_q - 4'd1;
    end
  end

  // Control FSM with registered outputs; the message register shifts right one beat per cycle
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      msg_q   <= '0;
      beat_q  <= '0;
      crd_q   <= CRD_FULL;
      ovf_q   <= 1'b0;
      ptr_q   <= 2'd0;
      grant_q <= '0;
      vld_q   <= 1'b0;
      cfg_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      crd_q   <= crd_d;
      ovf_q   <= ovf_d;
      grant_q <= '0;
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q <= SEND;
            msg_q   <= sel_msg >> N;
            cfg_q   <= sel_msg[N-1:0];
            vld_q   <= 1'b1;
            busy_q  <= 1'b1;
            grant_q <= sel_oh;
            beat_q  <= '0;
            ptr_q   <= (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
          end
        end
        SEND: begin
          if (beat_q == BEAT_LAST) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            cfg_q   <= '0;
            busy_q  <= 1'b0;
            beat_q  <= '0;
          end else begin
            beat_q <= beat_q + 4'd1;
            cfg_q  <= msg_q[N-1:0];
            msg_q  <= msg_q >> N;
          end
        end
      endcase
    end
  end

  assign bus.o_lp_cfg       = cfg_q;
  assign bus.o_lp_cfg_vld   = vld_q;
  assign bus.o_grant        = grant_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_crd_count    = crd_q;
  assign bus.o_crd_overflow = ovf_q;

endmodule

// File: tb/tb_ucie_ctl_sb_tx_arbiter.sv
// Bench for the sideband TX arbiter: N=32 vector table, N=8 serialisation,
// N=64 with a single credit, and reset abort mid-message.
module tb_ucie_ctl_sb_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ucie_ctl_sb_tx_arbiter_if #(.N(32)) if32 ();
  ucie_ctl_sb_tx_arbiter_if #(.N(8))  if8  ();
  ucie_ctl_sb_tx_arbiter_if #(.N(64)) if64 ();

  ucie_ctl_sb_tx_arbiter #(.N(32), .CRD_MAX(4)) u32 (.i_clk(clk), .i_rst(rst), .bus(if32.slave));
  ucie_ctl_sb_tx_arbiter #(.N(8),  .CRD_MAX(4)) u8  (.i_clk(clk), .i_rst(rst), .bus(if8.slave));
  ucie_ctl_sb_tx_arbiter #(.N(64), .CRD_MAX(1)) u64 (.i_clk(clk), .i_rst(rst), .bus(if64.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic        crd;
    logic [2:0]  g;
    logic        vld;
    logic [31:0] cfg;
    logic        busy;
    logic [3:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl[27];

  localparam logic [63:0] MA = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] M1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] M2 = 64'h5555_6666_7777_8888;

  initial begin
    logic [63:0] m8;
    m8 = 64'h0123_4567_89AB_CDEF;

    // N=32 table: inputs applied, one edge, then expected registered outputs
    tbl[0]  = '{3'b001, 1'b0, 3'b001, 1'b1, 32'hCCCC_DDDD, 1'b1, 4'd3, 1'b0};
    tbl[1]  = '{3'b000, 1'b0, 3'b000, 1'b1, 32'hAAAA_BBBB, 1'b1, 4'd3, 1'b0};
    tbl[2]  = '{3'b000, 1'b0, 3'b000, 1'b0, 32'h0,         1'b0, 4'd3, 1'b0};
    tbl[3]  = '{3'b111, 1'b1, 3'b010, 1'b1, 32'h3333_4444, 1'b1, 4'd3, 1'b0};
    tbl[4]  = '{3'b111, 1'b0, 3'b000, 1'b1, 32'h1111_2222, 1'b1, 4'd3, 1'b0};
    tbl[5]  = '{3'b111, 1'b0, 3'b000, 1'b0, 32'h0,         1'b0, 4'd3, 1'b0};
    tbl[6]  = '{3'b111, 1'b0, 3'b100, 1'b1, 32'h7777_8888, 1'b1, 4'd2, 1'b0};
    tbl[7]  = '{3'b111, 1'b0, 3'b000, 1'b1, 32'h5555_6666, 1'b1, 4'd2, 1'b0};
    tbl[8]  = '{3'b111, 1'b0, 3'b000, 1'b0, 32'h0,         1'b0, 4'd2, 1'b0};
    tbl[9]  = '{3'b111, 1'b0, 3'b001, 1'b1, 32'hCCCC_DDDD, 1'b1, 4'd1, 1'b0};
    tbl[10] = '{3'b111, 1'b0, 3'b000, 1'b1, 32'hAAAA_BBBB, 1'b1, 4'd1, 1'b0};
    tbl[11] = '{3'b111, 1'b0, 3'b000, 1'b0, 32'h0,         1'b0, 4'd1, 1'b0};
    tbl[12] = '{3'b111, 1'b0, 3'b010, 1'b1, 32'h3333_4444, 1'b1, 4'd0, 1'b0};
    tbl[13] = '{3'b000, 1'b0, 3'b000, 1'b1, 32'h1111_2222, 1'b1, 4'd0, 1'b0};
    tbl[14] = '{3'b000, 1'b0, 3'b000, 1'b0, 32'h0,         1'b0, 4'd0, 1'b0};
    tbl[15] = '{3'b001, 1'b0, 3'b000, 1'b0, 32'h0,         1'b0, 4'd0, 1'b0};
    tbl[16] = '{3'b001, 1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 4'd1, 1'b0};
    tbl[17] = '{3'b001, 1'b0, 3'b001, 1'b1, 32'hCCCC_DDDD, 1'b1, 4'd0, 1'b0};
    tbl[18] = '{3'b000, 1'b0, 3'b000, 1'b1, 32'hAAAA_BBBB, 1'b1, 4'd0, 1'b0};
    tbl[19] = '{3'b000, 1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 4'd1, 1'b0};
    tbl[20] = '{3'b000, 1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 4'd2, 1'b0};
    tbl[21] = '{3'b000, 1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 4'd3, 1'b0};
    tbl[22] = '{3'b000, 1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 4'd4, 1'b0};
    tbl[23] = '{3'b000, 1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 4'd4, 1'b1};
    tbl[24] = '{3'b010, 1'b1, 3'b010, 1'b1, 32'h3333_4444, 1'b1, 4'd4, 1'b1};
    tbl[25] = '{3'b000, 1'b0, 3'b000, 1'b1, 32'h1111_2222, 1'b1, 4'd4, 1'b1};
    tbl[26] = '{3'b000, 1'b0, 3'b000, 1'b0, 32'h0,         1'b0, 4'd4, 1'b1};

    if32.i_req = '0; if32.i_msg0 = MA; if32.i_msg1 = M1; if32.i_msg2 = M2; if32.i_pl_cfg_crd = 1'b0;
    if8.i_req  = '0; if8.i_msg0  = m8; if8.i_msg1  = '0; if8.i_msg2  = '0; if8.i_pl_cfg_crd  = 1'b0;
    if64.i_req = '0; if64.i_msg0 = MA; if64.i_msg1 = M1; if64.i_msg2 = '0; if64.i_pl_cfg_crd = 1'b0;

    // Reset values
    #12;
    chk("rst vld32",  64'(if32.o_lp_cfg_vld),   64'd0);
    chk("rst cfg32",  64'(if32.o_lp_cfg),       64'd0);
    chk("rst grant32",64'(if32.o_grant),        64'd0);
    chk("rst busy32", 64'(if32.o_busy),         64'd0);
    chk("rst crd32",  64'(if32.o_crd_count),    64'd4);
    chk("rst ovf32",  64'(if32.o_crd_overflow), 64'd0);
    chk("rst crd64",  64'(if64.o_crd_count),    64'd1);

    // N=8: capture on the first edge after release, eight bytes LSB first
    if8.i_req = 3'b001;
    rst = 1'b1;
    step();
    if8.i_req = 3'b000;
    chk("n8 crd", 64'(if8.o_crd_count), 64'd3);
    for (int b = 0; b < 8; b++) begin
      if (b > 0) step();
      chk($sformatf("n8 grant b%0d", b), 64'(if8.o_grant), (b == 0) ? 64'd1 : 64'd0);
      chk($sformatf("n8 vld b%0d", b),   64'(if8.o_lp_cfg_vld), 64'd1);
      chk($sformatf("n8 busy b%0d", b),  64'(if8.o_busy), 64'd1);
      chk($sformatf("n8 cfg b%0d", b),   64'(if8.o_lp_cfg), 64'(m8[b*8 +: 8]));
    end
    step();
    chk("n8 end vld",  64'(if8.o_lp_cfg_vld), 64'd0);
    chk("n8 end busy", 64'(if8.o_busy),       64'd0);
    chk("n8 end cfg",  64'(if8.o_lp_cfg),     64'd0);

    // N=64, one credit: second request waits for a credit return
    if64.i_req = 3'b011;
    step();
    chk("n64 grant0", 64'(if64.o_grant),      64'd1);
    chk("n64 cfg0",   64'(if64.o_lp_cfg),     MA);
    chk("n64 vld0",   64'(if64.o_lp_cfg_vld), 64'd1);
    chk("n64 crd0",   64'(if64.o_crd_count),  64'd0);
    if64.i_req = 3'b010;
    step();
    chk("n64 vld1",   64'(if64.o_lp_cfg_vld), 64'd0);
    chk("n64 busy1",  64'(if64.o_busy),       64'd0);
    chk("n64 cfg1",   64'(if64.o_lp_cfg),     64'd0);
    step();
    chk("n64 wait grant", 64'(if64.o_grant),  64'd0);
    chk("n64 wait vld",   64'(if64.o_lp_cfg_vld), 64'd0);
    if64.i_pl_cfg_crd = 1'b1;
    step();
    if64.i_pl_cfg_crd = 1'b0;
    chk("n64 ret crd",   64'(if64.o_crd_count), 64'd1);
    chk("n64 ret grant", 64'(if64.o_grant),     64'd0);
    step();
    chk("n64 grant1", 64'(if64.o_grant),     64'd2);
    chk("n64 cfg2",   64'(if64.o_lp_cfg),    M1);
    chk("n64 crd2",   64'(if64.o_crd_count), 64'd0);
    if64.i_req = 3'b000;
    step();
    chk("n64 end vld", 64'(if64.o_lp_cfg_vld), 64'd0);

    // N=32 vector table
    for (int i = 0; i < 27; i++) begin
      if32.i_req        = tbl[i].req;
      if32.i_pl_cfg_crd = tbl[i].crd;
      step();
      chk($sformatf("v%0d grant", i), 64'(if32.o_grant),        64'(tbl[i].g));
      chk($sformatf("v%0d vld", i),   64'(if32.o_lp_cfg_vld),   64'(tbl[i].vld));
      chk($sformatf("v%0d cfg", i),   64'(if32.o_lp_cfg),       64'(tbl[i].cfg));
      chk($sformatf("v%0d busy", i),  64'(if32.o_busy),         64'(tbl[i].busy));
      chk($sformatf("v%0d crd", i),   64'(if32.o_crd_count),    64'(tbl[i].cnt));
      chk($sformatf("v%0d ovf", i),   64'(if32.o_crd_overflow), 64'(tbl[i].ovf));
    end
    if32.i_pl_cfg_crd = 1'b0;

    // Reset during the first beat aborts and reloads credits and pointer
    if32.i_req = 3'b001;
    step();
    chk("abort grant", 64'(if32.o_grant),    64'd1);
    chk("abort beat0", 64'(if32.o_lp_cfg),   64'hCCCC_DDDD);
    chk("abort crd",   64'(if32.o_crd_count),64'd3);
    if32.i_req = 3'b000;
    rst = 1'b0;
    #1;
    chk("abort vld",   64'(if32.o_lp_cfg_vld),   64'd0);
    chk("abort cfg",   64'(if32.o_lp_cfg),       64'd0);
    chk("abort busy",  64'(if32.o_busy),         64'd0);
    chk("abort crd4",  64'(if32.o_crd_count),    64'd4);
    chk("abort ovf",   64'(if32.o_crd_overflow), 64'd0);
    step();
    chk("abort held vld", 64'(if32.o_lp_cfg_vld), 64'd0);
    if32.i_req = 3'b111;
    rst = 1'b1;
    step();
    chk("post rst grant", 64'(if32.o_grant),     64'd1);
    chk("post rst cfg",   64'(if32.o_lp_cfg),    64'hCCCC_DDDD);
    chk("post rst crd",   64'(if32.o_crd_count), 64'd3);
    if32.i_req = 3'b000;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
